// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared gate-drive state encoding and timing defaults
package dds_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    DEAD  = 2'd1,
    HS_ON = 2'd2,
    LS_ON = 2'd3
  } leg_state_t;

  localparam int DEAD_CYCLES_DEF = 8;
  localparam int MIN_PULSE_DEF   = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/deadtime_leg.sv
// rtl/deadtime_leg.sv - one half-bridge leg: pwm register, dead-time/min-pulse FSM, gate regs
module deadtime_leg
  import dds_pkg::*;
#(
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
  parameter int MIN_PULSE   = MIN_PULSE_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic force_off,
  input  logic pwm_in,
  output logic hs_gate,
  output logic ls_gate
);

  localparam int CNT_W = $clog2(max_int(DEAD_CYCLES, MIN_PULSE) + 1);
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_LOAD  = CNT_W'(MIN_PULSE - 1);

  leg_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pwm_q;

  // Gates decode the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state   <= OFF;
      cnt     <= '0;
      pwm_q   <= 1'b0;
      hs_gate <= 1'b0;
      ls_gate <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pwm_q   <= pwm_in;
      hs_gate <= (state_nxt == HS_ON);
      ls_gate <= (state_nxt == LS_ON);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt != '0) ? cnt - 1'b1 : '0;
    if (force_off) begin
      state_nxt = OFF;
      cnt_nxt   = '0;
    end else begin
      case (state)
        OFF: begin
          state_nxt = DEAD;
          cnt_nxt   = DEAD_LOAD;
        end
        DEAD: begin
          if (cnt == '0) begin
            state_nxt = pwm_q ? HS_ON : LS_ON;
            cnt_nxt   = MIN_LOAD;
          end
        end
        HS_ON: begin
          if (cnt == '0 && !pwm_q) begin
            state_nxt = DEAD;
            cnt_nxt   = DEAD_LOAD;
          end
        end
        LS_ON: begin
          if (cnt == '0 && pwm_q) begin
            state_nxt = DEAD;
            cnt_nxt   = DEAD_LOAD;
          end
        end
        default: begin
          state_nxt = OFF;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pwm_deadtime_gen.sv
// rtl/pwm_deadtime_gen.sv - multi-leg complementary gate drive with dead time and fault latch
module pwm_deadtime_gen
  import dds_pkg::*;
#(
  parameter int NLEGS       = 2,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
  parameter int MIN_PULSE   = MIN_PULSE_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [NLEGS-1:0] pwm_in,
  input  logic             fault_in,
  input  logic             fault_clr,
  output logic [NLEGS-1:0] hs_gate,
  output logic [NLEGS-1:0] ls_gate,
  output logic             fault_latched
);

  logic force_off;

  // A clear request is only honoured once the fault source has gone away.
  always_ff @(posedge clk) begin
    if (resetn) begin
      fault_latched <= 1'b0;
    end else if (fault_in) begin
      fault_latched <= 1'b1;
    end else if (fault_clr) begin
      fault_latched <= 1'b0;
    end
  end

  assign force_off = fault_latched | fault_in | ~en;

  for (genvar i = 0; i < NLEGS; i++) begin : g_leg
    deadtime_leg #(
      .DEAD_CYCLES(DEAD_CYCLES),
      .MIN_PULSE  (MIN_PULSE)
    ) u_leg (
      .clk      (clk),
      .resetn   (resetn),
      .force_off(force_off),
      .pwm_in   (pwm_in[i]),
      .hs_gate  (hs_gate[i]),
      .ls_gate  (ls_gate[i])
    );
  end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// tb/tb_pwm_deadtime_gen.sv - directed and randomized checks of pwm_deadtime_gen
module tb_pwm_deadtime_gen;

  localparam int NLEGS = 2;
  localparam int DEAD  = 8;
  localparam int MINP  = 4;

  logic             clk = 1'b0;
  logic             resetn, en, fault_in, fault_clr;
  logic [NLEGS-1:0] pwm_in, hs_gate, ls_gate;
  logic             fault_latched;

  always #5 clk = ~clk;

  pwm_deadtime_gen #(.NLEGS(NLEGS), .DEAD_CYCLES(DEAD), .MIN_PULSE(MINP)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .en           (en),
    .pwm_in       (pwm_in),
    .fault_in     (fault_in),
    .fault_clr    (fault_clr),
    .hs_gate      (hs_gate),
    .ls_gate      (ls_gate),
    .fault_latched(fault_latched)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: each leg is idle, in a dead gap, or driving one gate,
  // with the age (clocks spent) of the current phase.
  bit               m_fault;
  bit [NLEGS-1:0]   m_pwm_q;
  bit               m_dead [NLEGS];
  int               m_gate [NLEGS];   // 0 none, +1 high side, -1 low side
  int               m_age  [NLEGS];
  int               low_run  [NLEGS];
  int               prev_hi  [NLEGS]; // gate high in the previous sampled cycle

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit force_off;
    force_off = m_fault | fault_in | !en;
    if (resetn) begin
      m_fault = 0;
      m_pwm_q = '0;
      for (int i = 0; i < NLEGS; i++) begin
        m_dead[i] = 0; m_gate[i] = 0; m_age[i] = 0;
      end
      return;
    end
    for (int i = 0; i < NLEGS; i++) begin
      if (force_off) begin
        m_dead[i] = 0; m_gate[i] = 0; m_age[i] = 0;
      end else if (!m_dead[i] && m_gate[i] == 0) begin
        m_dead[i] = 1; m_age[i] = 1;
      end else if (m_dead[i]) begin
        if (m_age[i] >= DEAD) begin
          m_dead[i] = 0;
          m_gate[i] = m_pwm_q[i] ? 1 : -1;
          m_age[i]  = 1;
        end else m_age[i]++;
      end else begin
        if (m_age[i] >= MINP && (m_pwm_q[i] != (m_gate[i] == 1))) begin
          m_gate[i] = 0; m_dead[i] = 1; m_age[i] = 1;
        end else if (m_age[i] < 1000) m_age[i]++;
      end
    end
    if (fault_in) m_fault = 1;
    else if (fault_clr) m_fault = 0;
    m_pwm_q = pwm_in;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < NLEGS; i++) begin
      int hi;
      check($sformatf("hs_gate[%0d]", i), 32'(hs_gate[i]), 32'(m_gate[i] == 1));
      check($sformatf("ls_gate[%0d]", i), 32'(ls_gate[i]), 32'(m_gate[i] == -1));
      check($sformatf("overlap[%0d]", i), 32'(hs_gate[i] & ls_gate[i]), 32'd0);
      hi = hs_gate[i] ? 1 : (ls_gate[i] ? -1 : 0);
      if (hi != 0) begin
        if (hi != prev_hi[i])
          check($sformatf("dead_gap_ok[%0d]", i), 32'(low_run[i] >= DEAD), 32'd1);
        low_run[i] = 0;
      end else low_run[i]++;
      prev_hi[i] = hi;
    end
    check("fault_latched", 32'(fault_latched), 32'(m_fault));
  endtask

  task automatic step_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int cnt;
    bit ls_seen;
    for (int i = 0; i < NLEGS; i++) begin
      low_run[i] = DEAD; prev_hi[i] = 0;
      m_dead[i] = 0; m_gate[i] = 0; m_age[i] = 0;
    end
    m_fault = 0; m_pwm_q = '0;
    resetn = 1; en = 0; pwm_in = '0; fault_in = 0; fault_clr = 0;
    #1;

    // 1) reset, then enable with pwm low: ls rises on the 9th edge
    step_n(2);
    check("reset_hs", 32'(hs_gate), 32'd0);
    check("reset_ls", 32'(ls_gate), 32'd0);
    check("reset_fault", 32'(fault_latched), 32'd0);
    resetn = 0; en = 1;
    step_n(8);
    check("ls_low_before_9th", 32'(ls_gate), 32'd0);
    step();
    check("ls_rise_9th", 32'(ls_gate), 32'h3);
    check("hs_stays_low", 32'(hs_gate), 32'd0);
    step_n(3);

    // 2) leg 0 switches LS -> HS with exactly DEAD clocks of gap
    pwm_in = 2'b01;
    step();
    check("ls_held_at_E0", 32'(ls_gate[0]), 32'd1);
    step();
    check("ls_drop_at_E1", 32'(ls_gate[0]), 32'd0);
    cnt = 0;
    while (!hs_gate[0] && cnt < 20) begin step(); cnt++; end
    check("dead_gap_len", 32'(cnt), 32'(DEAD));

    // 3) short low pulse is stretched to MIN_PULSE on the low side
    step_n(5);
    pwm_in[0] = 0;
    cnt = 0;
    while (!ls_gate[0] && cnt < 20) begin step(); cnt++; end
    check("ls_reached", 32'(ls_gate[0]), 32'd1);
    pwm_in[0] = 1;
    cnt = 1;
    while (ls_gate[0] && cnt < 20) begin step(); if (ls_gate[0]) cnt++; end
    check("ls_min_pulse", 32'(cnt), 32'(MINP));

    // 4) glitch within the dead window is ignored; ends in HS with no LS
    pwm_in[0] = 0;
    step_n(2);
    pwm_in[0] = 1;
    ls_seen = 0;
    for (int k = 0; k < 10; k++) begin step(); ls_seen |= ls_gate[0]; end
    check("dead_glitch_hs", 32'(hs_gate[0]), 32'd1);
    check("dead_glitch_no_ls", 32'(ls_seen), 32'd0);

    // 5) fault handling
    fault_in = 1;
    step();
    check("fault_gates_off", 32'({hs_gate, ls_gate}), 32'd0);
    check("fault_set", 32'(fault_latched), 32'd1);
    fault_clr = 1;
    step();
    check("clr_ignored_while_fault", 32'(fault_latched), 32'd1);
    fault_clr = 0; fault_in = 0;
    step();
    check("latched_after_fault_drop", 32'(fault_latched), 32'd1);
    fault_clr = 1;
    step();
    check("fault_cleared", 32'(fault_latched), 32'd0);
    fault_clr = 0;
    ls_seen = 0;
    for (int k = 0; k < DEAD; k++) begin step(); ls_seen |= |{hs_gate, ls_gate}; end
    check("dead_after_clear", 32'(ls_seen), 32'd0);
    step();
    check("hs_after_clear", 32'(hs_gate[0]), 32'd1);

    // 6a) reset mid HS_ON and mid DEAD
    resetn = 1;
    step();
    check("reset_mid_on", 32'({hs_gate, ls_gate}), 32'd0);
    resetn = 0;
    step_n(4);
    resetn = 1;
    step();
    check("reset_mid_dead", 32'({hs_gate, ls_gate}), 32'd0);
    resetn = 0;

    // 6b) randomized run against the model
    for (int c = 0; c < 20000; c++) begin
      for (int i = 0; i < NLEGS; i++)
        if ($urandom_range(15) == 0) pwm_in[i] = ~pwm_in[i];
      resetn    = ($urandom_range(499) == 0);
      fault_in  = ($urandom_range(699) == 0) ? 1'b1 : (fault_in & ($urandom_range(3) != 0));
      fault_clr = ($urandom_range(19) == 0);
      if ($urandom_range(399) == 0) en = ~en;
      else if (!en && $urandom_range(9) == 0) en = 1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
